// File: rtl/imem_loader.sv
// imem_loader: instruction-memory responder for the PMIPSL processor family.
// Answers the processor fetch port combinationally from an internal 17-bit RAM
// and provides a byte-serial load port that fills the RAM while the processor
// is held in reset.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   imemaddr  [16:0]      processor fetch byte address
//   imemrdata [16:0]      instruction word (combinational, zero outside RUN)
//   load_req              level: high requests a load session
//   load_valid, load_byte byte stream; accepted when load_valid && load_ready
//   load_ready            high while a load session is open
//   cpu_reset             processor reset, held across a session
//   word_count [AW:0]     words written in the current or last session
//   load_err              sticky: last session ended on a partial word
//   overflow              sticky: last session sent more than DEPTH words
module imem_loader #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [16:0]   imemaddr,
   output logic [16:0]   imemrdata,
   input  logic          load_req,
   input  logic          load_valid,
   input  logic [7:0]    load_byte,
   output logic          load_ready,
   output logic          cpu_reset,
   output logic [AW:0]   word_count,
   output logic          load_err,
   output logic          overflow
);

   localparam int unsigned IW = 17;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {RUN, B0, B1, B2} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   wc_d;
   logic            err_d, ovf_d;
   logic            hi_q, hi_d;
   logic [7:0]      mid_q, mid_d;
   logic            ready_d, cpu_reset_d;
   logic            we_c;

   logic [IW-1:0]   mem [DEPTH];

   // State and control registers; RAM contents are deliberately not reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         ptr_q      <= '0;
         word_count <= '0;
         load_err   <= 1'b0;
         overflow   <= 1'b0;
         hi_q       <= 1'b0;
         mid_q      <= '0;
         load_ready <= 1'b0;
         cpu_reset  <= 1'b1;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         word_count <= wc_d;
         load_err   <= err_d;
         overflow   <= ovf_d;
         hi_q       <= hi_d;
         mid_q      <= mid_d;
         load_ready <= ready_d;
         cpu_reset  <= cpu_reset_d;
      end
   end

   // Next-state logic; load_req is checked before any byte is taken.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wc_d    = word_count;
      err_d   = load_err;
      ovf_d   = overflow;
      hi_d    = hi_q;
      mid_d   = mid_q;
      we_c    = 1'b0;

      unique case (state_q)
         RUN: begin
            if (load_req) begin
               state_d = B0;
               ptr_d   = '0;
               wc_d    = '0;
               err_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         B0: begin
            if (!load_req) begin
               state_d = RUN;
            end else if (load_valid) begin
               hi_d    = load_byte[0];
               state_d = B1;
            end
         end
         B1: begin
            if (!load_req) begin
               state_d = RUN;
               err_d   = 1'b1;
            end else if (load_valid) begin
               mid_d   = load_byte;
               state_d = B2;
            end
         end
         B2: begin
            if (!load_req) begin
               state_d = RUN;
               err_d   = 1'b1;
            end else if (load_valid) begin
               state_d = B0;
               // Pointer never wraps: surplus words are dropped, not overwritten.
               if (ptr_q == CW'(DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  we_c  = 1'b1;
                  ptr_d = ptr_q + CW'(1);
               end
               if (word_count != CW'(DEPTH)) begin
                  wc_d = word_count + CW'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase

      ready_d     = (state_d != RUN);
      // Rises with session entry, releases one edge after RUN is re-entered.
      cpu_reset_d = (state_d != RUN) || (state_q != RUN);
   end

   // RAM write port
   always_ff @(posedge clock) begin
      if (we_c) begin
         mem[ptr_q[AW-1:0]] <= {hi_q, mid_q, load_byte};
      end
   end

   // Asynchronous fetch; out-of-range addresses and load sessions read zero.
   always_comb begin
      imemrdata = '0;
      if ((state_q == RUN) && ((imemaddr >> CW) == 17'd0)) begin
         imemrdata = mem[imemaddr[AW:1]];
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table for fetches, scoreboard
// queue of expected read data, and hand sequences for session corner cases.
module tb_imem_loader;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned AW    = 7;

   logic          clock;
   logic          reset;
   logic [16:0]   imemaddr;
   logic [16:0]   imemrdata;
   logic          load_req;
   logic          load_valid;
   logic [7:0]    load_byte;
   logic          load_ready;
   logic          cpu_reset;
   logic [AW:0]   word_count;
   logic          load_err;
   logic          overflow;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .imemaddr   (imemaddr),
      .imemrdata  (imemrdata),
      .load_req   (load_req),
      .load_valid (load_valid),
      .load_byte  (load_byte),
      .load_ready (load_ready),
      .cpu_reset  (cpu_reset),
      .word_count (word_count),
      .load_err   (load_err),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [16:0] addr;
      logic [16:0] exp;
   } vec_t;

   vec_t          vecs [7];
   int            pass_cnt  = 0;
   int            total_cnt = 0;
   logic [16:0]   exp_q [$];
   logic [16:0]   model_mem [DEPTH];
   int            model_ptr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Expected value goes into the scoreboard when the address is driven.
   task automatic fetch(input logic [16:0] addr, input logic [16:0] exp, input string name);
      logic [16:0] e;
      exp_q.push_back(exp);
      imemaddr = addr;
      @(negedge clock);
      e = exp_q.pop_front();
      chk(name, 32'(imemrdata), 32'(e));
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (!load_ready && n < 20) begin
         tick();
         n++;
      end
      if (!load_ready) chk("ready_timeout", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_byte  = b;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic send_word(input logic [16:0] w, input int gap, input bit check_ready);
      logic [7:0] bytes [3];
      bytes[0] = {7'd0, w[16]};
      bytes[1] = w[15:8];
      bytes[2] = w[7:0];
      for (int k = 0; k < 3; k++) begin
         send_byte(bytes[k]);
         for (int g = 0; g < gap; g++) begin
            tick();
            if (check_ready) chk("ready_in_gap", 32'(load_ready), 32'd1);
         end
      end
      if (model_ptr < int'(DEPTH)) model_mem[model_ptr] = w;
      model_ptr++;
   endtask

   task automatic start_session();
      load_req  = 1'b1;
      model_ptr = 0;
      tick();
   endtask

   function automatic logic [16:0] wgen(input int i);
      logic [16:0] r;
      r = {1'(i), 8'(i * 7 + 1), 8'(i)};
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{addr: 17'h00000, exp: 17'h16183};
      vecs[1] = '{addr: 17'h00002, exp: 17'h0E581};
      vecs[2] = '{addr: 17'h00004, exp: 17'h0DC07};
      vecs[3] = '{addr: 17'h00001, exp: 17'h16183};
      vecs[4] = '{addr: 17'h00005, exp: 17'h0DC07};
      vecs[5] = '{addr: 17'h10000, exp: 17'h00000};
      vecs[6] = '{addr: 17'h00100, exp: 17'h00000};

      reset      = 1'b1;
      imemaddr   = '0;
      load_req   = 1'b0;
      load_valid = 1'b0;
      load_byte  = '0;
      repeat (2) @(posedge clock);
      #2;
      chk("rst_cpu_reset",  32'(cpu_reset),  32'd1);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_load_err",   32'(load_err),   32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      reset = 1'b0;
      tick();
      chk("cpu_reset_release", 32'(cpu_reset), 32'd0);

      // Bytes offered in RUN are ignored.
      load_valid = 1'b1;
      load_byte  = 8'hFF;
      repeat (3) tick();
      load_valid = 1'b0;
      chk("run_valid_ready", 32'(load_ready), 32'd0);
      chk("run_valid_wc",    32'(word_count), 32'd0);

      // Back-to-back load of three words.
      start_session();
      chk("b0_ready",     32'(load_ready), 32'd1);
      chk("b0_cpu_reset", 32'(cpu_reset),  32'd1);
      send_word(17'h16183, 0, 1'b0);
      send_word(17'h0E581, 0, 1'b0);
      send_word(17'h0DC07, 0, 1'b0);
      chk("wc_three", 32'(word_count), 32'd3);
      fetch(17'h00000, 17'h00000, "fetch_in_session");
      load_req = 1'b0;
      tick();
      chk("cpu_reset_hold",  32'(cpu_reset),  32'd1);
      chk("ready_after_end", 32'(load_ready), 32'd0);
      tick();
      chk("cpu_reset_fall", 32'(cpu_reset), 32'd0);
      for (int i = 0; i < 7; i++) fetch(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

      // Same words with bubbles between bytes.
      start_session();
      send_word(17'h16183, 2, 1'b1);
      send_word(17'h0E581, 2, 1'b1);
      send_word(17'h0DC07, 2, 1'b1);
      chk("gap_wc", 32'(word_count), 32'd3);
      load_req = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 7; i++) fetch(vecs[i].addr, vecs[i].exp, $sformatf("gap_vec%0d", i));

      // Session ends mid-word; a byte presented with the fall is dropped.
      start_session();
      send_word(17'h12345, 0, 1'b0);
      send_byte(8'h00);
      load_req   = 1'b0;
      load_valid = 1'b1;
      load_byte  = 8'hAA;
      tick();
      load_valid = 1'b0;
      chk("partial_wc",    32'(word_count), 32'd1);
      chk("partial_err",   32'(load_err),   32'd1);
      chk("partial_ready", 32'(load_ready), 32'd0);
      tick();
      fetch(17'h00002, model_mem[1], "partial_word1");
      fetch(17'h00000, model_mem[0], "partial_word0");

      // DEPTH+1 words: last one dropped, nothing overwritten.
      start_session();
      chk("err_cleared", 32'(load_err), 32'd0);
      for (int i = 0; i <= int'(DEPTH); i++) begin
         if (i == int'(DEPTH)) chk("no_ovf_at_depth", 32'(overflow), 32'd0);
         send_word(wgen(i), 0, 1'b0);
      end
      chk("ovf_set", 32'(overflow),   32'd1);
      chk("ovf_wc",  32'(word_count), 32'(DEPTH));
      load_req = 1'b0;
      repeat (2) tick();
      chk("ovf_sticky", 32'(overflow), 32'd1);
      fetch(17'h00000, model_mem[0], "ovf_word0");
      fetch(17'(2 * (DEPTH - 1)), model_mem[DEPTH-1], "ovf_last");
      chk("ovf_word0_first", 32'(model_mem[0]), 32'(wgen(0)));

      // Reset during B1 of the second word.
      start_session();
      send_word(17'h1ABCD, 0, 1'b0);
      send_byte(8'h01);
      reset = 1'b1;
      #1;
      chk("midrst_cpu_reset", 32'(cpu_reset),  32'd1);
      chk("midrst_wc",        32'(word_count), 32'd0);
      chk("midrst_ready",     32'(load_ready), 32'd0);
      load_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      fetch(17'h00000, model_mem[0], "midrst_word0");
      chk("midrst_cpu_run", 32'(cpu_reset), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the PMIPSL processor family: answers the processor's instruction fetch port (`imemaddr` to `imemrdata`) from an internal 17-bit-wide RAM. It also provides a byte-serial load port that fills that RAM while holding the processor in reset. It replaces the hand-driven instruction stream in simulation and on the board, and sits beside the data memory/IO device.

## Interface
- `DEPTH`, 128: number of 17-bit instruction words; a power of two, minimum 4.
- `AW`, 7: word-index width, equal to log2(DEPTH).
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `imemaddr`  in  17: processor fetch address, byte-addressed.
- `imemrdata`  out  17: instruction word returned to the processor.
- `load_req`  in  1: level signal; high requests a load session.
- `load_valid`  in  1: `load_byte` is valid this cycle.
- `load_byte`  in  8: load data byte.
- `load_ready`  out  1: byte accepted when `load_valid && load_ready`.
- `cpu_reset`  out  1: drives the processor's reset input.
- `word_count`  out  AW+1: number of words written in the current or most recent session.
- `load_err`  out  1: sticky flag; the last session ended on a partial word.
- `overflow`  out  1: sticky flag; the last session sent more than DEPTH words.

## Operation
- FSM states: RUN, B0, B1, B2. Reset places the FSM in RUN.
- Reset values:
  - `cpu_reset` = 1.
  - `word_count` = 0, `load_err` = 0, `overflow` = 0.
  - `load_ready` = 0.
  - Write pointer = 0.
  - RAM contents are not touched by reset.
- Fetch (all states):
  - Word index = `imemaddr[AW:1]`; `imemaddr[0]` is ignored.
  - Any nonzero `imemaddr[16:AW+1]` returns 17'd0.
  - In any state other than RUN, `imemrdata` = 17'd0.
- RUN:
  - `load_ready` = 0.
  - On `load_req` = 1: go to B0; clear the pointer, `word_count`, `load_err` and `overflow`.
- B0/B1/B2:
  - `load_ready` = 1.
  - Each accepted byte advances B0 to B1 to B2 to B0.
  - B0 byte: bit 0 is instruction bit 16; bits 7:1 are ignored.
  - B1 byte: instruction bits 15:8.
  - B2 byte: instruction bits 7:0.
- Word commit (on the B2 byte accept):
  - The assembled word is written at the pointer, and the pointer increments.
  - `word_count` increments, saturating at DEPTH.
  - If the pointer already equals DEPTH, the word is dropped and `overflow` is set. The pointer does not wrap, so earlier words are never overwritten.
- `load_req` falling in B0: go to RUN.
- `load_req` falling in B1 or B2:
  - Go to RUN, discard the partial word, and set `load_err`.
  - A byte accepted in the same cycle as the fall is discarded.
- `load_req` priority: the `load_req` level is sampled before byte acceptance.
- `cpu_reset`:
  - Registered; 1 in B0, B1 and B2.
  - Deasserts on the first clock edge after the FSM enters RUN, so the processor starts at PC = 0 with a fully written RAM.
- `reset` mid-session: the FSM returns to RUN with all outputs at reset values. Words already committed remain in RAM.

## Timing
- Fetch is combinational (asynchronous RAM read):
  - `imemrdata` is valid in the same cycle as `imemaddr`.
  - Zero-cycle latency, as the multicycle processor expects.
- Load write: a word written by the B2 accept at edge N is readable after edge N.
- Maximum load rate is one byte per cycle, i.e. one word per 3 cycles.
- `load_req` rising in RUN at edge N:
  - State is B0 after edge N.
  - `cpu_reset` is high after edge N+1 at the latest.
- `load_req` falling at edge M:
  - State is RUN after edge M.
  - `cpu_reset` falls after edge M+1.
- `load_valid` while in RUN is ignored; no handshake occurs.

## Test plan
- Reset, then load 3 words: bytes 01/61/83, 00/E5/81, 00/DC/07 with `load_valid` every cycle, then drop `load_req`.
  - `word_count` = 3.
  - `imemaddr` 0, 2, 4 return 17'h16183, 17'h0E581, 17'h0DC07.
  - `cpu_reset` falls one cycle after RUN is entered.
- Gapped `load_valid` (bubbles between bytes): same RAM contents as the back-to-back case; `load_ready` stays high throughout.
- Drop `load_req` after 4 bytes: `word_count` = 1, `load_err` = 1, word 1 unchanged, state RUN.
- Send DEPTH+1 words: `overflow` = 1, `word_count` = DEPTH, word 0 still holds the first word loaded.
- Assert `reset` during B1 of the second word:
  - `cpu_reset` = 1 and `word_count` = 0 immediately.
  - Word 0 is still readable after reset is released.
- `imemaddr` = 17'h10000 in RUN returns 0; any fetch during a load session returns 0.
